// File: rtl/udma_uart_rx_deser.sv
// udma_uart_rx_deser: uart rx front end - synchroniser, bit sampler, parity/stop checks and 1-entry holding register
module udma_uart_rx_deser #(
  parameter int DIV_WIDTH  = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  periph_clk_i,
  input  logic                  rstn_i,
  input  logic                  cfg_en_i,
  input  logic [DIV_WIDTH-1:0]  cfg_div_i,
  input  logic [1:0]            cfg_bits_i,
  input  logic                  cfg_parity_en_i,
  input  logic                  cfg_parity_odd_i,
  input  logic                  cfg_stop_bits_i,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  rx_char_event_o,
  output logic                  err_parity_o,
  output logic                  err_frame_o,
  output logic                  err_overrun_o
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  state_e                  state_q, state_d;
  logic [1:0]              rx_sync_q;
  logic                    rx_q, rx_s, fall, tick, eof;
  logic [DIV_WIDTH-1:0]    cnt_q, cnt_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic                    stop_idx_q, stop_idx_d;
  logic [7:0]              shift_q, shift_d;
  logic                    par_q, par_d, frm_q, frm_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d, busy_q;
  logic                    char_q, char_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  assign rx_s = rx_sync_q[1];
  assign fall = rx_q & ~rx_s;
  assign tick = cnt_q == cfg_div_i;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + DIV_WIDTH'(1);
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    frm_d      = frm_q;
    eof        = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = START;
          shift_d = '0;
          par_d   = 1'b0;
          frm_d   = 1'b0;
        end
      end
      START: if (cnt_q == (cfg_div_i >> 1)) begin
        cnt_d     = '0;
        bit_idx_d = '0;
        state_d   = rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_d              = '0;
        shift_d[bit_idx_q] = rx_s;
        bit_idx_d          = bit_idx_q + 3'd1;
        if (bit_idx_q == {1'b1, cfg_bits_i}) begin
          state_d    = cfg_parity_en_i ? PARITY : STOP;
          stop_idx_d = 1'b0;
        end
      end
      PARITY: if (tick) begin
        cnt_d      = '0;
        par_d      = ^shift_q ^ rx_s ^ cfg_parity_odd_i;
        state_d    = STOP;
        stop_idx_d = 1'b0;
      end
      STOP: if (tick) begin
        cnt_d = '0;
        frm_d = frm_q | ~rx_s;
        if (stop_idx_q < cfg_stop_bits_i) stop_idx_d = 1'b1;
        else begin
          eof     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!cfg_en_i) begin
      state_d = IDLE;
      eof     = 1'b0;
    end
  end
  // frame-error frames are discarded; a full holding register drops the new character
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~ready_i;
    char_d  = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    if (eof) begin
      perr_d = par_q;
      if (frm_d) ferr_d = 1'b1;
      else if (!valid_q || ready_i) begin
        data_d  = DATA_WIDTH'(shift_q);
        valid_d = 1'b1;
        char_d  = 1'b1;
      end else ovr_d = 1'b1;
    end
  end
  always_ff @(posedge periph_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_sync_q  <= 2'b11;
      rx_q       <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      frm_q      <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      char_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rx_i};
      rx_q       <= rx_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      frm_q      <= frm_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= state_d != IDLE;
      char_q     <= char_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end
  assign data_o          = data_q;
  assign valid_o         = valid_q;
  assign busy_o          = busy_q;
  assign rx_char_event_o = char_q;
  assign err_parity_o    = perr_q;
  assign err_frame_o     = ferr_q;
  assign err_overrun_o   = ovr_q;
endmodule

// File: tb/tb_udma_uart_rx_deser.sv
// tb_udma_uart_rx_deser: directed and random uart frames checked against a frame-level model
module tb_udma_uart_rx_deser;
  logic        clk = 1'b0, rstn = 1'b0, en = 1'b1, pen = 1'b0, podd = 1'b0, stop2 = 1'b0;
  logic        rx = 1'b1, ready = 1'b1;
  logic [15:0] div = 16'd15;
  logic [1:0]  bits = 2'b11;
  logic [7:0]  data_o;
  logic        valid_o, busy_o, char_o, perr_o, ferr_o, ovr_o, v_prev = 1'b0;
  int          total = 0, bad = 0;
  int          n_char = 0, n_par = 0, n_frm = 0, n_ovr = 0, n_valid = 0, n_busy = 0;
  int          b_char, b_par, b_frm, b_ovr, b_valid, b_busy;
  time         t_fall = 0, t_valid = 0;

  udma_uart_rx_deser #(.DIV_WIDTH(16), .DATA_WIDTH(8)) dut (
    .periph_clk_i(clk), .rstn_i(rstn), .cfg_en_i(en), .cfg_div_i(div), .cfg_bits_i(bits),
    .cfg_parity_en_i(pen), .cfg_parity_odd_i(podd), .cfg_stop_bits_i(stop2), .rx_i(rx),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready), .busy_o(busy_o),
    .rx_char_event_o(char_o), .err_parity_o(perr_o), .err_frame_o(ferr_o), .err_overrun_o(ovr_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn) begin
      n_char  += int'(char_o);
      n_par   += int'(perr_o);
      n_frm   += int'(ferr_o);
      n_ovr   += int'(ovr_o);
      n_valid += int'(valid_o);
      n_busy  += int'(busy_o);
    end
    if (valid_o && !v_prev) t_valid = $time;
    v_prev = valid_o;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_char = n_char; b_par = n_par; b_frm = n_frm; b_ovr = n_ovr; b_valid = n_valid; b_busy = n_busy;
  endtask

  function automatic logic par_of(input logic [7:0] d, input int nb);
    logic p = 1'b0;
    for (int i = 0; i < nb; i++) p ^= d[i];
    return p;
  endfunction

  task automatic hold_bit(input logic b);
    rx = b;
    repeat (int'(div) + 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // drives one frame from the current tb config; pflip corrupts parity, slow drives the last stop bit low
  task automatic send(input logic [7:0] d, input bit pflip, input bit slow);
    int nb = int'(bits) + 5;
    t_fall = $time;
    hold_bit(1'b0);
    for (int i = 0; i < nb; i++) hold_bit(d[i]);
    if (pen) hold_bit(par_of(d, nb) ^ podd ^ pflip);
    if (stop2) hold_bit(1'b1);
    hold_bit(~slow);
    rx = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_pulses", 32'({char_o, perr_o, ferr_o, ovr_o}), 32'h0);
    rstn = 1'b1;
    idle(5);

    snap();
    send(8'hA5, 1'b0, 1'b0);
    idle(20);
    chk("t1_data", 32'(data_o), 32'hA5);
    chk("t1_char", 32'(n_char - b_char), 32'd1);
    chk("t1_errs", 32'((n_par - b_par) + (n_frm - b_frm) + (n_ovr - b_ovr)), 32'd0);
    chk("t1_valid_cycles", 32'(n_valid - b_valid), 32'd1);
    // cycles counted inclusively from the cycle rx_i falls to the first cycle valid_o is high
    chk("t1_latency", 32'((t_valid - t_fall) / 10 + 1), 32'd156);

    div = 16'd7; bits = 2'b10; pen = 1'b1; podd = 1'b0; ready = 1'b0;
    snap();
    send(8'h35, 1'b1, 1'b0);
    idle(16);
    chk("t2_data", 32'(data_o), 32'h35);
    chk("t2_valid", 32'(valid_o), 32'h1);
    chk("t2_char", 32'(n_char - b_char), 32'd1);
    chk("t2_perr", 32'(n_par - b_par), 32'd1);
    ready = 1'b1;
    idle(2);
    ready = 1'b0;
    podd = 1'b1;
    snap();
    send(8'h35, 1'b0, 1'b0);
    idle(16);
    chk("t2b_data", 32'(data_o), 32'h35);
    chk("t2b_char", 32'(n_char - b_char), 32'd1);
    chk("t2b_perr", 32'(n_par - b_par), 32'd0);
    ready = 1'b1;
    idle(2);

    div = 16'd15; bits = 2'b11; pen = 1'b0; podd = 1'b0; stop2 = 1'b1;
    snap();
    send(8'h3C, 1'b0, 1'b1);
    idle(20);
    chk("t3_frm", 32'(n_frm - b_frm), 32'd1);
    chk("t3_char", 32'(n_char - b_char), 32'd0);
    chk("t3_valid", 32'(valid_o), 32'h0);

    stop2 = 1'b0; ready = 1'b0;
    snap();
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    idle(40);
    chk("t4_data", 32'(data_o), 32'h11);
    chk("t4_valid", 32'(valid_o), 32'h1);
    chk("t4_ovr", 32'(n_ovr - b_ovr), 32'd1);
    chk("t4_char", 32'(n_char - b_char), 32'd1);
    ready = 1'b1;
    @(negedge clk);
    chk("t4_valid_drop", 32'(valid_o), 32'h0);
    idle(5);

    snap();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    chk("t5_busy_le8", 32'((n_busy - b_busy) <= 8 && (n_busy - b_busy) > 0), 32'd1);
    chk("t5_pulses", 32'((n_char - b_char) + (n_par - b_par) + (n_frm - b_frm) + (n_ovr - b_ovr)), 32'd0);

    ready = 1'b0;
    send(8'hC3, 1'b0, 1'b0);
    idle(20);
    snap();
    rx = 1'b0;
    repeat (48) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_dis_busy", 32'(busy_o), 32'h0);
    idle(20);
    chk("t6_dis_valid", 32'(valid_o), 32'h1);
    chk("t6_dis_data", 32'(data_o), 32'hC3);
    chk("t6_dis_pulses", 32'((n_char - b_char) + (n_par - b_par) + (n_frm - b_frm) + (n_ovr - b_ovr)), 32'd0);
    en = 1'b1; ready = 1'b1;
    idle(5);
    snap();
    send(8'h5A, 1'b0, 1'b0);
    idle(20);
    chk("t6_dis_next_data", 32'(data_o), 32'h5A);
    chk("t6_dis_next_char", 32'(n_char - b_char), 32'd1);
    rx = 1'b0;
    repeat (60) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("t6_rst_busy", 32'(busy_o), 32'h0);
    chk("t6_rst_valid", 32'(valid_o), 32'h0);
    chk("t6_rst_data", 32'(data_o), 32'h0);
    rx = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    idle(20);
    snap();
    send(8'h5A, 1'b0, 1'b0);
    idle(20);
    chk("t6_rst_next_data", 32'(data_o), 32'h5A);
    chk("t6_rst_next_char", 32'(n_char - b_char), 32'd1);

    for (int k = 0; k < 8; k++) begin
      logic [7:0] d;
      logic       pf, sl;
      int         nb;
      div   = 16'($urandom_range(3, 12));
      bits  = 2'($urandom_range(0, 3));
      pen   = 1'($urandom_range(0, 1));
      podd  = 1'($urandom_range(0, 1));
      stop2 = 1'($urandom_range(0, 1));
      d     = 8'($urandom);
      pf    = pen & 1'($urandom_range(0, 1));
      sl    = $urandom_range(0, 3) == 0;
      nb    = int'(bits) + 5;
      snap();
      send(d, pf, sl);
      idle(2 * (int'(div) + 1));
      if (!sl) chk($sformatf("rnd%0d_data", k), 32'(data_o), 32'(d & 8'((1 << nb) - 1)));
      chk($sformatf("rnd%0d_char", k), 32'(n_char - b_char), 32'(!sl));
      chk($sformatf("rnd%0d_perr", k), 32'(n_par - b_par), 32'(pf));
      chk($sformatf("rnd%0d_frm", k), 32'(n_frm - b_frm), 32'(sl));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/udma_uart_rx_deser.md
Name: udma_uart_rx_deser

Overview:
- Receive-side serial front end of the uDMA UART.
- Takes the raw rx pad input, synchronises it, and recovers characters using a programmable per-bit clock divider.
- Checks parity and stop bits, and presents each character through a 1-entry valid/ready holding register to the uDMA RX channel logic.
- Generates pulse events for character received and for each error class.

Parameters:
DIV_WIDTH, 16, width of the baud divider and its bit-period counter
DATA_WIDTH, 8, width of the character output; characters shorter than this are zero-extended

Ports:
periph_clk_i  in  1  block clock
rstn_i  in  1  reset, asynchronous, active-low
cfg_en_i  in  1  receiver enable
cfg_div_i  in  DIV_WIDTH  bit period = cfg_div_i+1 clock cycles; minimum legal value 3
cfg_bits_i  in  2  data bits: 00=5, 01=6, 10=7, 11=8
cfg_parity_en_i  in  1  parity bit present
cfg_parity_odd_i  in  1  1=odd, 0=even parity
cfg_stop_bits_i  in  1  0=one stop bit, 1=two stop bits
rx_i  in  1  asynchronous serial input, idle high
data_o  out  DATA_WIDTH  received character, LSB = first data bit
valid_o  out  1  data_o holds an unread character
ready_i  in  1  consumer accepts data_o
busy_o  out  1  FSM not in IDLE
rx_char_event_o  out  1  one-cycle pulse when a character is loaded
err_parity_o  out  1  one-cycle pulse on a parity mismatch
err_frame_o  out  1  one-cycle pulse when a stop bit is sampled low
err_overrun_o  out  1  one-cycle pulse when a character is dropped because the holding register is full

Behaviour:
- Reset values:
  - data_o=0; valid_o=0; busy_o=0; all pulse outputs 0.
  - FSM=IDLE.
  - Both synchroniser flops and the previous-sample flop reset to 1.
- Input synchronisation:
  - Two-flop synchroniser on rx_i produces rx_s.
  - rx_q holds rx_s delayed by one cycle.
  - A falling edge is rx_q=1 and rx_s=0.
- Counters:
  - cnt (DIV_WIDTH bits) counts clock cycles within the current bit.
  - bit_idx (3 bits) counts data bits.
  - stop_idx (1 bit) counts stop bits.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On a falling edge with cfg_en_i=1: go to START, set cnt=0.
  - Otherwise stay in IDLE.
- START:
  - cnt increments each cycle.
  - At cnt==cfg_div_i>>1 (the mid-bit point), sample rx_s:
    - rx_s=0: go to DATA, set cnt=0, bit_idx=0.
    - rx_s=1: treat as a glitch, return to IDLE; no error pulse.
- DATA:
  - Each time cnt==cfg_div_i, sample rx_s into shift[bit_idx] and set cnt=0. This lands at mid-bit because of the half-bit offset taken in START.
  - After bit number cfg_bits_i+4 is sampled:
    - go to PARITY if cfg_parity_en_i=1;
    - otherwise go to STOP with stop_idx=0.
- PARITY:
  - When cnt==cfg_div_i, sample the parity bit.
  - The parity error flag is set when (XOR of the received data bits) XOR (parity bit) XOR cfg_parity_odd_i equals 1.
  - Go to STOP with stop_idx=0.
- STOP:
  - When cnt==cfg_div_i, sample the stop bit. A 0 sets the frame error flag.
  - If stop_idx < cfg_stop_bits_i: increment stop_idx and stay in STOP.
  - Otherwise, end the frame in the same cycle and return to IDLE. A new start edge is accepted from the next cycle, i.e. half a bit early.
- End of frame, evaluated in the cycle of the last stop sample; the listed outputs change on the following cycle:
  - Frame error: pulse err_frame_o; the character is discarded and no rx_char_event_o is generated. If a parity error was also flagged, err_parity_o pulses as well.
  - Otherwise, if valid_o=0, or valid_o=1 with ready_i=1 in the same cycle: data_o ← zero-extended shift, valid_o=1, pulse rx_char_event_o. A parity error pulses err_parity_o and the character is still delivered.
  - Otherwise (valid_o=1, ready_i=0): pulse err_overrun_o; data_o and valid_o are unchanged and the new character is lost.
- Handshake:
  - valid_o deasserts on the cycle after valid_o=1 and ready_i=1, unless a new character loads in that same cycle.
  - data_o is stable while valid_o=1 and ready_i=0.
- Latency: from the rx_i falling edge, valid_o rises 2 (synchroniser) + 1 (edge detect) + frame sample time + 1 cycles later.
- Disable: cfg_en_i=0 in any state forces IDLE on the next cycle. The partial character is dropped, no pulses are generated, and the holding register and valid_o are retained.
- Configuration: cfg_div_i, cfg_bits_i and the parity and stop fields may change only while busy_o=0. cfg_div_i<3 is out of spec.
- busy_o = (state != IDLE), registered.

Test Plan:
1. cfg_div_i=15, 8N1, send 0xA5, ready_i=1 → data_o=0xA5 and valid_o for 1 cycle; rx_char_event_o pulses once; no error pulses; start-edge-to-valid_o delay = 2+1+8+9×16+1 = 156 cycles.
2. cfg_div_i=7, 7 bits, even parity, 1 stop; send 0x35 with a wrong parity bit → data_o=0x35, valid_o=1, err_parity_o and rx_char_event_o pulse; repeat with odd parity and a correct parity bit → no err_parity_o.
3. 8N2, cfg_div_i=15, second stop bit driven low while sending 0x3C → err_frame_o pulses, valid_o stays 0, no rx_char_event_o.
4. ready_i=0, send 0x11 then 0x22 back-to-back → data_o=0x11 held; err_overrun_o pulses once at the end of the 0x22 frame; raise ready_i → valid_o drops the next cycle.
5. Low glitch of 4 cycles on rx_i with cfg_div_i=15 → the START check at cnt=7 sees 1, FSM returns to IDLE, no pulses; busy_o high for ≤8 cycles.
6. cfg_en_i dropped mid-DATA, and a separate case with rstn_i asserted mid-frame → FSM in IDLE, busy_o=0, no pulses, valid_o unchanged by the disable and 0 after reset; the next clean 0x5A frame is received correctly.
